// File: rtl/tdc_digital_if.sv
// tdc_digital_if
// Bundles the measurement-side signals of the digital TDC back end.
//   en           : enables measurement (driven by the controller)
//   ripple_count : free-running DCO period counter from tdc_analog
//   phase        : DCO phase-tap thermometer snapshot from tdc_analog
//   tdc_word     : absolute DCO phase in units of T_dco/(2*NPH)
//   tdc_diff     : phase advance over the last reference period, modulo 2^W
//   tdc_valid    : tdc_diff is meaningful this cycle
//   bubble_err   : one-update flag for an invalid phase code
//   bubble_cnt   : saturating count of invalid phase codes
// The master modport is the side that drives inputs and reads results;
// the slave modport is the TDC itself.
interface tdc_digital_if #(
  parameter int CNT_W = 7,
  parameter int NPH   = 16
);
  localparam int FRAC_W = $clog2(2 * NPH);
  localparam int W      = CNT_W + FRAC_W;

  logic             en;
  logic [CNT_W-1:0] ripple_count;
  logic [NPH-1:0]   phase;
  logic [W-1:0]     tdc_word;
  logic [W-1:0]     tdc_diff;
  logic             tdc_valid;
  logic             bubble_err;
  logic [7:0]       bubble_cnt;

  modport master (
    output en, ripple_count, phase,
    input  tdc_word, tdc_diff, tdc_valid, bubble_err, bubble_cnt
  );

  modport slave (
    input  en, ripple_count, phase,
    output tdc_word, tdc_diff, tdc_valid, bubble_err, bubble_cnt
  );
endinterface

// File: rtl/tdc_digital.sv
// tdc_digital
// Digital back end of the time-to-digital converter. Samples the DCO
// ripple counter and phase taps, decodes the taps into a fine phase,
// builds an absolute phase word and its per-reference-period difference.
// Ports:
//   clk : 32 MHz reference clock, all state changes on the rising edge
//   rst : synchronous active-high reset, takes priority over en
//   bus : tdc_digital_if slave modport (en, ripple_count, phase in;
//         tdc_word, tdc_diff, tdc_valid, bubble_err, bubble_cnt out)
module tdc_digital #(
  parameter int CNT_W = 7,
  parameter int NPH   = 16
) (
  input  logic          clk,
  input  logic          rst,
  tdc_digital_if.slave  bus
);
  localparam int FRAC_W = $clog2(2 * NPH);
  localparam int W      = CNT_W + FRAC_W;

  typedef enum logic [1:0] {IDLE, FILL1, FILL2, RUN} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   ripple_s0_q;
  logic [NPH-1:0]     phase_s0_q;
  logic [FRAC_W-1:0]  fine_last_q;
  logic [W-1:0]       word_q;
  logic [W-1:0]       diff_q;
  logic               valid_q;
  logic               bubble_err_q;
  logic [7:0]         bubble_cnt_q;

  logic               upd;
  logic               valid_d;
  logic [FRAC_W-1:0]  pop;
  logic [NPH-1:0]     phase_inv;
  logic               lower_ok;
  logic               upper_ok;
  logic               bubble;
  logic [FRAC_W-1:0]  fine_code;
  logic [FRAC_W-1:0]  fine_sel;
  logic [W-1:0]       word_d;
  logic [W-1:0]       diff_d;

  // Pipeline-fill sequencer. Two fill states cover the stage-0 register and
  // the first word update, so a difference is only flagged valid once two
  // real words exist. Dropping en at any point restarts the whole fill.
  // The word pipeline advances only while the sequencer is active and en is
  // still high, so the word freezes on the edge where en falls.
  always_comb begin
    state_d = state_q;
    if (!bus.en) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    state_d = FILL1;
        FILL1:   state_d = FILL2;
        FILL2:   state_d = RUN;
        RUN:     state_d = RUN;
        default: state_d = IDLE;
      endcase
    end
    upd     = bus.en && (state_q != IDLE);
    valid_d = (state_d == RUN);
  end

  // Thermometer decode of the sampled phase taps. A lower-half code is a
  // run of ones from bit 0 (x & (x+1) == 0); an upper-half code is the
  // bitwise complement of such a run with the top tap set. In the upper
  // half the fine phase counts on past NPH as the ones recede, giving
  // 2*NPH - popcount. Anything else is a bubble and reuses the last good
  // fine value so the word stays plausible.
  always_comb begin
    pop = '0;
    for (int i = 0; i < NPH; i++) begin
      pop = pop + FRAC_W'(phase_s0_q[i]);
    end
    phase_inv = ~phase_s0_q;
    lower_ok  = !phase_s0_q[NPH-1] &&
                ((phase_s0_q & (phase_s0_q + NPH'(1))) == '0);
    upper_ok  = phase_s0_q[NPH-1] &&
                ((phase_inv & (phase_inv + NPH'(1))) == '0);
    bubble    = !(lower_ok || upper_ok);
    if (phase_s0_q[NPH-1]) begin
      fine_code = FRAC_W'(2 * NPH - int'(pop));
    end else begin
      fine_code = pop;
    end
    fine_sel = bubble ? fine_last_q : fine_code;
    word_d   = {ripple_s0_q, fine_sel};
    diff_d   = word_d - word_q;
  end

  // State and datapath registers. Stage 0 samples the analog side on every
  // edge; the word, difference and bubble bookkeeping move only on update
  // edges so they hold steady while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      ripple_s0_q  <= '0;
      phase_s0_q   <= '0;
      fine_last_q  <= '0;
      word_q       <= '0;
      diff_q       <= '0;
      valid_q      <= 1'b0;
      bubble_err_q <= 1'b0;
      bubble_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      ripple_s0_q <= bus.ripple_count;
      phase_s0_q  <= bus.phase;
      valid_q     <= valid_d;
      if (upd) begin
        word_q       <= word_d;
        diff_q       <= diff_d;
        bubble_err_q <= bubble;
        if (bubble) begin
          if (bubble_cnt_q != 8'hFF) begin
            bubble_cnt_q <= bubble_cnt_q + 8'd1;
          end
        end else begin
          fine_last_q <= fine_code;
        end
      end
    end
  end

  assign bus.tdc_word   = word_q;
  assign bus.tdc_diff   = diff_q;
  assign bus.tdc_valid  = valid_q;
  assign bus.bubble_err = bubble_err_q;
  assign bus.bubble_cnt = bubble_cnt_q;
endmodule

// File: tb/tb_tdc_digital.sv
// tb_tdc_digital
// Self-checking bench for tdc_digital. Drives directed vectors followed by
// random traffic and compares every output after every edge against a
// behavioural model that thinks in terms of "samples from two edges ago"
// and "number of consecutive enabled edges".
module tb_tdc_digital;
  logic clk;
  logic rst;

  int nCompared;
  int nMismatch;

  // Behavioural model state
  int expWord;
  int expDiff;
  int expValid;
  int expErr;
  int expCnt;
  int lastFine;
  int enRun;
  int prevRipple;
  int prevPhase;

  tdc_digital_if #(.CNT_W(7), .NPH(16)) bus ();

  tdc_digital #(.CNT_W(7), .NPH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running reference clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Counts one comparison and reports it if the observed value is wrong
  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    nCompared++;
    if (obs !== exp) begin
      nMismatch++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Reference decode: returns the fine phase for a legal thermometer code,
  // or -1 for a bubble
  function automatic int decodeRef(input int p);
    int lowMask;
    for (int k = 0; k < 16; k++) begin
      lowMask = (1 << k) - 1;
      if (p == lowMask) return k;
      if (p == (32'hFFFF ^ lowMask)) return 16 + k;
    end
    return -1;
  endfunction

  // Advance the model by one edge with the inputs present at that edge
  task automatic modelStep(input logic r, input logic e, input int rc,
                           input int ph);
    int f;
    int w;
    if (r) begin
      expWord = 0; expDiff = 0; expValid = 0; expErr = 0; expCnt = 0;
      lastFine = 0; enRun = 0; prevRipple = 0; prevPhase = 0;
    end else begin
      if (e && enRun >= 1) begin
        f = decodeRef(prevPhase);
        if (f < 0) begin
          expErr = 1;
          if (expCnt < 255) expCnt++;
          f = lastFine;
        end else begin
          expErr = 0;
          lastFine = f;
        end
        w = prevRipple * 32 + f;
        expDiff = (w - expWord) & 12'hFFF;
        expWord = w;
      end
      enRun = e ? enRun + 1 : 0;
      expValid = (enRun >= 3) ? 1 : 0;
      prevRipple = rc;
      prevPhase = ph;
    end
  endtask

  // Drive one set of inputs, clock them in, and check all outputs
  task automatic applyStimulus(input logic r, input logic e,
                               input logic [6:0] rc, input logic [15:0] ph);
    @(negedge clk);
    rst = r;
    bus.en = e;
    bus.ripple_count = rc;
    bus.phase = ph;
    @(posedge clk);
    modelStep(r, e, int'(rc), int'(ph));
    #1;
    checkOutput("tdc_word",   32'(bus.tdc_word),   32'(expWord));
    checkOutput("tdc_diff",   32'(bus.tdc_diff),   32'(expDiff));
    checkOutput("tdc_valid",  32'(bus.tdc_valid),  32'(expValid));
    checkOutput("bubble_err", 32'(bus.bubble_err), 32'(expErr));
    checkOutput("bubble_cnt", 32'(bus.bubble_cnt), 32'(expCnt));
  endtask

  // Random phase code: mostly legal thermometer codes, sometimes garbage
  function automatic logic [15:0] randPhase();
    int k;
    int m;
    k = $urandom_range(0, 15);
    m = (1 << k) - 1;
    case ($urandom_range(0, 3))
      0:       return 16'(m);
      1:       return 16'(32'hFFFF ^ m);
      2:       return 16'(m);
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    nCompared = 0;
    nMismatch = 0;
    rst = 1'b1;
    bus.en = 1'b0;
    bus.ripple_count = '0;
    bus.phase = '0;
    modelStep(1'b1, 1'b0, 0, 0);

    // Reset state
    applyStimulus(1, 0, 0, 16'h0000);
    applyStimulus(1, 0, 0, 16'h0000);
    checkOutput("rst_word",  32'(bus.tdc_word),   0);
    checkOutput("rst_valid", 32'(bus.tdc_valid),  0);
    checkOutput("rst_cnt",   32'(bus.bubble_cnt), 0);

    // Basic decode: 5*32+4 then 6*32+8
    applyStimulus(0, 1, 5, 16'h000F);
    applyStimulus(0, 1, 6, 16'h00FF);
    checkOutput("dec_word164", 32'(bus.tdc_word), 164);
    checkOutput("dec_valid0",  32'(bus.tdc_valid), 0);
    applyStimulus(0, 1, 6, 16'h00FF);
    checkOutput("dec_word200", 32'(bus.tdc_word), 200);
    checkOutput("dec_diff36",  32'(bus.tdc_diff), 36);
    checkOutput("dec_valid1",  32'(bus.tdc_valid), 1);

    // Upper-half decode
    applyStimulus(0, 1, 0, 16'hFFF0);
    applyStimulus(0, 1, 0, 16'hFFFF);
    checkOutput("up_fine20", 32'(bus.tdc_word), 20);
    applyStimulus(0, 1, 0, 16'h0000);
    checkOutput("up_fine16", 32'(bus.tdc_word), 16);
    applyStimulus(0, 1, 0, 16'h0000);
    checkOutput("up_fine0",  32'(bus.tdc_word), 0);

    // Ripple counter wrap
    applyStimulus(0, 1, 127, 16'hFFFF);
    applyStimulus(0, 1, 0, 16'h0003);
    checkOutput("wrap_word4080", 32'(bus.tdc_word), 4080);
    applyStimulus(0, 1, 0, 16'h0003);
    checkOutput("wrap_word2",  32'(bus.tdc_word), 2);
    checkOutput("wrap_diff18", 32'(bus.tdc_diff), 18);
    checkOutput("wrap_noerr",  32'(bus.bubble_err), 0);

    // Single bubble, then saturation
    applyStimulus(0, 1, 0, 16'h000F);
    applyStimulus(0, 1, 0, 16'h00F5);
    applyStimulus(0, 1, 0, 16'h000F);
    checkOutput("bub_err1",  32'(bus.bubble_err), 1);
    checkOutput("bub_fine4", 32'(bus.tdc_word), 4);
    checkOutput("bub_cnt1",  32'(bus.bubble_cnt), 1);
    applyStimulus(0, 1, 0, 16'h000F);
    checkOutput("bub_err0",  32'(bus.bubble_err), 0);
    for (int i = 0; i < 300; i++) applyStimulus(0, 1, 0, 16'h00F5);
    applyStimulus(0, 1, 0, 16'h000F);
    checkOutput("bub_sat255", 32'(bus.bubble_cnt), 255);

    // Enable timing: fall, then rise
    applyStimulus(0, 1, 9, 16'h0001);
    applyStimulus(0, 0, 10, 16'h0003);
    checkOutput("en_fall_valid", 32'(bus.tdc_valid), 0);
    applyStimulus(0, 0, 11, 16'h0007);
    applyStimulus(0, 1, 12, 16'h000F);
    checkOutput("en_E_valid", 32'(bus.tdc_valid), 0);
    applyStimulus(0, 1, 13, 16'h001F);
    checkOutput("en_E1_valid", 32'(bus.tdc_valid), 0);
    applyStimulus(0, 1, 14, 16'h003F);
    checkOutput("en_E2_valid", 32'(bus.tdc_valid), 1);

    // Reset during RUN with en held high
    applyStimulus(1, 1, 20, 16'h00FF);
    checkOutput("rr_word",  32'(bus.tdc_word), 0);
    checkOutput("rr_diff",  32'(bus.tdc_diff), 0);
    checkOutput("rr_valid", 32'(bus.tdc_valid), 0);
    checkOutput("rr_cnt",   32'(bus.bubble_cnt), 0);
    applyStimulus(0, 1, 21, 16'h0001);
    applyStimulus(0, 1, 22, 16'h0001);
    applyStimulus(0, 1, 23, 16'h0001);
    checkOutput("rr_valid_back", 32'(bus.tdc_valid), 1);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      applyStimulus(($urandom_range(0, 49) == 0),
                    ($urandom_range(0, 9) != 0),
                    7'($urandom), randPhase());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end
endmodule

// File: doc/tdc_digital.md
TDC_DIGITAL -- requirements
Module: tdc_digital

Interface
REQ-001 Parameter CNT_W, default 7: width of the ripple_count input, in DCO periods.
REQ-002 Parameter NPH, default 16: number of phase taps; fixed power of two. FRAC_W = log2(2*NPH) = 5. W = CNT_W+FRAC_W = 12.
REQ-003 The block SHALL have a single clock, clk (input, 1 bit), which is the 32 MHz reference clock; all state changes on the rising edge.
REQ-004 rst  input  1: synchronous, active-high reset.
REQ-005 en  input  1: enables measurement.
REQ-006 ripple_count  input  CNT_W: free-running DCO period counter from tdc_analog; wraps at 2^CNT_W.
REQ-007 phase  input  NPH: DCO phase-tap snapshot from tdc_analog.
REQ-008 tdc_word  output  W: absolute DCO phase in units of T_dco/32.
REQ-009 tdc_diff  output  W: phase advance over the last clk period, modulo 2^W.
REQ-010 tdc_valid  output  1: tdc_diff is valid this cycle.
REQ-011 bubble_err  output  1: one-cycle flag for an invalid phase code, aligned with the tdc_word update.
REQ-012 bubble_cnt  output  8: saturating count of invalid phase codes.

Function
REQ-013 Stage 0 SHALL register ripple_count and phase on every edge, regardless of en.
REQ-014 Fine decode from stage-0 phase, with p = popcount:
- phase[NPH-1]=0 and the code is ones in bits [k-1:0], zeros above (k=0..15): fine = p.
- phase[NPH-1]=1 and the code is zeros in bits [k-1:0], ones above (k=0..15): fine = 16 + (16 - p).
REQ-015 Any other phase code is a bubble. On a bubble, fine SHALL equal the last valid fine (0 after reset), bubble_err SHALL be 1 for that update, and bubble_cnt SHALL increment, saturating at 255.
REQ-016 Word computation: word = {ripple_s0, fine}, i.e. ripple*32 + fine. tdc_word is registered one edge after stage 0.
REQ-017 Difference: tdc_diff = (tdc_word_new - tdc_word_prev) mod 2^W, registered on the same edge as the new tdc_word. The subtraction is unsigned and wraps; no saturation.
REQ-018 FSM states are IDLE, FILL1, FILL2, RUN.
- IDLE -> FILL1 at an edge where en=1.
- FILL1 -> FILL2 -> RUN on the next two edges while en=1.
- Any state -> IDLE at an edge where en=0.
REQ-019 tdc_valid SHALL be 1 exactly in the cycles following edges that leave the FSM in RUN. The first valid output appears 3 edges after en is first sampled high.
REQ-020 tdc_word and tdc_diff SHALL update on every edge while the FSM is not IDLE; in IDLE they hold their value.
REQ-021 bubble_err and bubble_cnt SHALL update only when tdc_word updates.
REQ-022 When en deasserts mid-RUN, tdc_valid SHALL be 0 after that edge, and the next en assertion SHALL repeat the full FILL sequence.
REQ-023 Wrap-around: a ripple_count wrap from 2^CNT_W-1 to 0 between samples SHALL yield the correct modular tdc_diff.

Reset
REQ-024 When rst=1 at an edge, the FSM SHALL go to IDLE and the following SHALL be cleared to 0: stage-0 registers, tdc_word, tdc_diff, tdc_valid, bubble_err, bubble_cnt, and the last valid fine.
REQ-025 rst SHALL take priority over en.
REQ-026 Reset asserted mid-RUN SHALL clear tdc_valid at that edge; the FILL sequence restarts after rst falls with en=1.

Verification
REQ-027 Decode check: en=1; ripple=5, phase=0x000F, then ripple=6, phase=0x00FF -> tdc_word 164 then 200; tdc_diff=36 with tdc_valid=1.
REQ-028 Upper-half decode: phase=0xFFF0 -> fine=20; phase=0xFFFF -> fine=16; phase=0x0000 -> fine=0.
REQ-029 Wrap: ripple=127, phase=0xFFFF (word 4080), then ripple=0, phase=0x0003 (word 2) -> tdc_diff=18, no error flag.
REQ-030 Bubble: after phase=0x000F, apply phase=0x00F5 -> bubble_err=1 for one cycle, fine stays 4, bubble_cnt=1. Repeat 300 bubbles -> bubble_cnt=255.
REQ-031 Enable timing: en rises, sampled at edge E -> tdc_valid=0 after E and E+1, 1 after E+2. en falls at edge D -> tdc_valid=0 after D, and tdc_word holds.
REQ-032 Reset: rst=1 for one edge during RUN with en=1 -> all outputs 0 and FSM in IDLE; tdc_valid returns to 1 three edges after rst falls.
